usb_bus_master: RTL
===================

USB_BUS_MASTER -- requirements
Module: usb_bus_master

Interface
REQ-001 Parameter CNT_W, default 4, width of each timing field and of the phase counter.
REQ-002 Reset is synchronous and active-high; the block has exactly one clock.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  8  target address.
REQ-009 cmd_wdata  in  8  write data.
REQ-010 cmd_burst  in  1  continue on the current address phase (used only with USBM_BURST_EN).
REQ-011 cfg_setup, cfg_strobe, cfg_hold  in  CNT_W each  phase lengths minus one, in cycles.
REQ-012 rsp_valid  out  1  one-cycle pulse at transaction completion.
REQ-013 rsp_rdata  out  8  last read data; holds its value between reads.
REQ-014 USB_Addr  out  8  address bus.
REQ-015 USB_D_o  out  8  data bus out.
REQ-016 USB_D_oe  out  1  data bus output enable.
REQ-017 USB_D_i  in  8  data bus in.
REQ-018 USB_ALEn, USB_CEn, USB_WRn, USB_RDn  out  1 each  active-low strobes.
REQ-019 busy  out  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, ADDR, STROBE and HOLD.
REQ-021 All bus outputs SHALL be registered.
REQ-022 On acceptance, the block SHALL capture cmd_write, cmd_addr, cmd_wdata, cmd_burst and the three cfg fields; later changes to these inputs SHALL have no effect on the transaction in flight.
REQ-023 ADDR: lasts cfg_setup+1 cycles; USB_Addr = captured address; ALEn=0, CEn=0, WRn=RDn=1.
REQ-024 STROBE: lasts cfg_strobe+1 cycles; ALEn=1, CEn=0.
  - Write: WRn=0, USB_D_oe=1, USB_D_o = wdata.
  - Read: RDn=0, USB_D_oe=0.
REQ-025 Read capture: rsp_rdata SHALL be loaded from USB_D_i on the last STROBE cycle only.
REQ-026 HOLD: lasts cfg_hold+1 cycles; WRn=RDn=1, CEn=0, USB_Addr held.
  - Write: USB_D_oe remains 1 and USB_D_o remains wdata.
  - Read: USB_D_oe=0.
REQ-027 The state after HOLD SHALL be IDLE.
  - In that first IDLE cycle: rsp_valid=1, cmd_ready=1, CEn=1, USB_D_oe=0.
REQ-028 Total occupancy from the acceptance edge SHALL be (cfg_setup+1)+(cfg_strobe+1)+(cfg_hold+1) cycles, then rsp_valid.
REQ-029 A cfg field of 0 SHALL produce exactly one cycle in that phase.
  - All-ones SHALL produce 2^CNT_W cycles.
  - The counter SHALL never wrap within a phase.
REQ-030 cmd_valid asserted outside IDLE SHALL be ignored; no command is queued.
REQ-031 A command presented in the same cycle as rsp_valid SHALL be accepted in that cycle.
REQ-032 USB_D_oe and WRn=0 SHALL never be asserted together with RDn=0.

Reset
REQ-033 While reset_i=1 at a clock edge, and in the cycle after it, the outputs SHALL be:
  - state = IDLE
  - ALEn=CEn=WRn=RDn=1
  - USB_D_oe=0
  - USB_Addr=0, USB_D_o=0
  - rsp_valid=0, rsp_rdata=0
  - busy=0, cmd_ready=0
REQ-034 cmd_ready SHALL rise in the first cycle after reset_i deasserts.
REQ-035 A reset asserted mid-transaction SHALL abort it with no rsp_valid, and all strobes SHALL go inactive on the next edge.

Configuration
REQ-036 The macro USBM_BURST_EN SHALL control burst operation.
REQ-037 With USBM_BURST_EN defined, a command accepted in the completion IDLE cycle with cmd_burst=1 SHALL:
  - skip ADDR and enter STROBE directly;
  - keep CEn=0 and USB_Addr unchanged across the IDLE cycle, with cmd_addr ignored;
  - occupy (cfg_strobe+1)+(cfg_hold+1) cycles.
REQ-038 A command with cmd_burst=1 accepted at any other time SHALL execute as a normal transaction.
REQ-039 Without USBM_BURST_EN, cmd_burst SHALL be ignored and every command SHALL execute the full ADDR/STROBE/HOLD sequence.

Verification
REQ-040 Write test: setup=1, strobe=2, hold=0, addr=0x2A, wdata=0xC3 -> ALEn low 2 cycles, WRn low 3 cycles with D_o=0xC3 and oe=1, HOLD 1 cycle, rsp_valid on cycle 7 after acceptance.
REQ-041 Read test: setup=0, strobe=0, hold=0, addr=0x05, USB_D_i=0x5A only on the STROBE cycle -> rsp_rdata=0x5A, rsp_valid 4 cycles after acceptance, oe=0 throughout.
REQ-042 Maximum phase lengths: all cfg=0xF -> 16+16+16 cycles, then rsp_valid; cmd_valid pulsed mid-transaction -> no second transaction.
REQ-043 Reset mid-operation: reset_i asserted in STROBE of a write -> next edge WRn=CEn=1, oe=0, no rsp_valid; a new read afterwards completes normally.
REQ-044 Burst (with USBM_BURST_EN): write 0x11 then burst write 0x22 at rsp_valid -> a single ALEn pulse, CEn continuously low, two WRn pulses, two rsp_valid pulses.
REQ-045 Burst (without USBM_BURST_EN): same stimulus as REQ-044 -> two ALEn pulses, CEn high for 1 cycle between the transactions.

Source files
------------

// File: rtl/usb_bus_master.sv
// usb_bus_master: registered ALE/CE/WR/RD bus sequencer, ADDR -> STROBE -> HOLD.
// Define USBM_BURST_EN to let back-to-back burst commands reuse the address phase.
module usb_bus_master #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [7:0]       cmd_addr,
    input  logic [7:0]       cmd_wdata,
    input  logic             cmd_burst,
    input  logic [CNT_W-1:0] cfg_setup,
    input  logic [CNT_W-1:0] cfg_strobe,
    input  logic [CNT_W-1:0] cfg_hold,
    output logic             rsp_valid,
    output logic [7:0]       rsp_rdata,
    output logic [7:0]       USB_Addr,
    output logic [7:0]       USB_D_o,
    output logic             USB_D_oe,
    input  logic [7:0]       USB_D_i,
    output logic             USB_ALEn,
    output logic             USB_CEn,
    output logic             USB_WRn,
    output logic             USB_RDn,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ADDR, STROBE, HOLD} state_t;

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] strobe_q, hold_q;
    logic             wr_q;
    logic [7:0]       wdata_q;

    logic             accept, last, burst_go, done_n;
    logic             wr_nx;
    logic [7:0]       wdata_nx, addr_nx;
    logic             ale_n, ce_n, wrn_n, rdn_n, oe_n;
    logic [7:0]       d_o_n;

    assign accept = cmd_valid & cmd_ready;
    assign last   = (cnt == '0);
    assign busy   = (state != IDLE);

`ifdef USBM_BURST_EN
    assign burst_go = accept & cmd_burst & rsp_valid;
`else
    logic unused_burst;
    assign unused_burst = cmd_burst;
    assign burst_go     = 1'b0;
`endif

    // Counter is loaded with the phase field and counts down to zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (burst_go) begin
                        state_n = STROBE;
                        cnt_n   = cfg_strobe;
                    end else begin
                        state_n = ADDR;
                        cnt_n   = cfg_setup;
                    end
                end
            end
            ADDR: begin
                if (last) begin
                    state_n = STROBE;
                    cnt_n   = strobe_q;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            STROBE: begin
                if (last) begin
                    state_n = HOLD;
                    cnt_n   = hold_q;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            HOLD: begin
                if (last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wr_nx    = accept ? cmd_write : wr_q;
        wdata_nx = accept ? cmd_wdata : wdata_q;
        addr_nx  = (accept & ~burst_go) ? cmd_addr : USB_Addr;
        ale_n    = (state_n != ADDR);
        ce_n     = (state_n == IDLE);
`ifdef USBM_BURST_EN
        // Chip select bridges the completion cycle so a burst can follow.
        if (done_n) ce_n = 1'b0;
`endif
        wrn_n = !((state_n == STROBE) && wr_nx);
        rdn_n = !((state_n == STROBE) && !wr_nx);
        oe_n  = ((state_n == STROBE) || (state_n == HOLD)) && wr_nx;
        d_o_n = oe_n ? wdata_nx : USB_D_o;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            strobe_q  <= '0;
            hold_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            USB_Addr  <= '0;
            USB_D_o   <= '0;
            USB_D_oe  <= 1'b0;
            USB_ALEn  <= 1'b1;
            USB_CEn   <= 1'b1;
            USB_WRn   <= 1'b1;
            USB_RDn   <= 1'b1;
        end else begin
            if (accept) begin
                strobe_q <= cfg_strobe;
                hold_q   <= cfg_hold;
            end
            wr_q      <= wr_nx;
            wdata_q   <= wdata_nx;
            cmd_ready <= (state_n == IDLE);
            rsp_valid <= done_n;
            if ((state == STROBE) && last && !wr_q) begin
                rsp_rdata <= USB_D_i;
            end
            USB_Addr <= addr_nx;
            USB_D_o  <= d_o_n;
            USB_D_oe <= oe_n;
            USB_ALEn <= ale_n;
            USB_CEn  <= ce_n;
            USB_WRn  <= wrn_n;
            USB_RDn  <= rdn_n;
        end
    end

endmodule
